bp_vc_wb_drain: RTL and testbench

- Receives dirty-block evictions from the victim cache's UCE-facing eviction interface and buffers them in a small FIFO.
- Serializes each buffered block into fixed-width writeback beats toward the UCE over a valid/ready handshake.
- Decouples single-cycle, non-stallable victim-cache evictions from a back-pressured memory path.
- Sits between the victim cache and the UCE writeback port.

---
 rtl/bp_vc_wb_drain.sv | 173 +++++++++++++++++
 tb/tb_bp_vc_wb_drain.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_vc_wb_drain.sv
// bp_vc_wb_drain
//
// Buffers dirty-block evictions from the victim cache in a small FIFO and
// serializes each buffered block into beat_width writeback beats toward the
// UCE. Evictions arrive as single-cycle strobes that cannot be stalled; the
// writeback side is back-pressured with a valid/ready handshake.
//
// Handshake: a beat transfers on a rising edge where wb_v_o=1 and
// wb_ready_i=1. While wb_v_o=1 and wb_ready_i=0 every wb_* output holds
// stable. wb_ready_i is ignored while wb_v_o=0.
//
// Ports:
//   clk_i          clock, rising edge
//   reset          asynchronous active-low reset
//   evict_i        eviction strobe (enqueue when not full and stat != 0)
//   evict_data_i   evicted block data
//   evict_tag_i    evicted block tag
//   evict_stat_i   evicted block status (0 = clean, dropped)
//   full_o         FIFO holds fifo_els entries
//   overflow_o     sticky: an eviction arrived while full
//   wb_v_o         writeback beat valid
//   wb_ready_i     UCE accepts the beat
//   wb_tag_o       tag of the block being drained
//   wb_stat_o      status of the block being drained
//   wb_beat_o      beat index within the block
//   wb_last_o      final beat of the block
//   wb_data_o      beat data, low beat first
//   busy_o         FIFO non-empty or drain in progress
module bp_vc_wb_drain #(
    parameter int block_width = 512,
    parameter int tag_width   = 28,
    parameter int stat_width  = 2,
    parameter int beat_width  = 64,
    parameter int fifo_els    = 2,
    localparam int nb_lp         = block_width / beat_width,
    localparam int beat_idx_w_lp = (nb_lp > 1) ? $clog2(nb_lp) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset,
    input  logic                     evict_i,
    input  logic [block_width-1:0]   evict_data_i,
    input  logic [tag_width-1:0]     evict_tag_i,
    input  logic [stat_width-1:0]    evict_stat_i,
    output logic                     full_o,
    output logic                     overflow_o,
    output logic                     wb_v_o,
    input  logic                     wb_ready_i,
    output logic [tag_width-1:0]     wb_tag_o,
    output logic [stat_width-1:0]    wb_stat_o,
    output logic [beat_idx_w_lp-1:0] wb_beat_o,
    output logic                     wb_last_o,
    output logic [beat_width-1:0]    wb_data_o,
    output logic                     busy_o
);

    localparam int ptr_w_lp = (fifo_els > 1) ? $clog2(fifo_els) : 1;
    localparam int cnt_w_lp = $clog2(fifo_els + 1);
    localparam logic [beat_idx_w_lp-1:0] last_beat_lp = beat_idx_w_lp'(nb_lp - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [ptr_w_lp-1:0]      rd_q, rd_d, wr_q, wr_d;
    logic [cnt_w_lp-1:0]      cnt_q, cnt_d;
    logic [beat_idx_w_lp-1:0] beat_q, beat_d;
    logic                     ovf_q, ovf_d;
    logic                     enq, pop, full;

    logic [block_width-1:0]   data_mem_q [fifo_els];
    logic [tag_width-1:0]     tag_mem_q  [fifo_els];
    logic [stat_width-1:0]    stat_mem_q [fifo_els];
    logic [block_width-1:0]   head_data;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(fifo_els - 1)) ? '0 : p + 1'b1;
    endfunction

    // Full is judged on the registered count, so a pop in the same cycle
    // never makes room for that cycle's eviction.
    assign full = (cnt_q == cnt_w_lp'(fifo_els));
    assign enq  = evict_i & ~full & (|evict_stat_i);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        pop     = 1'b0;
        ovf_d   = ovf_q | (evict_i & full);
        if (enq) wr_d = ptr_inc(wr_q);
        case (state_q)
            IDLE: begin
                if (cnt_q != '0) begin
                    state_d = SEND;
                    beat_d  = '0;
                end
            end
            SEND: begin
                if (wb_ready_i) begin
                    if (beat_q == last_beat_lp) begin
                        pop    = 1'b1;
                        beat_d = '0;
                        rd_d   = ptr_inc(rd_q);
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        cnt_d = cnt_q + cnt_w_lp'(enq) - cnt_w_lp'(pop);
        // Stay in SEND after the last beat only if another block is queued,
        // which lets back-to-back blocks stream without a bubble.
        if (pop && (cnt_d == '0)) state_d = IDLE;
    end

    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            beat_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            ovf_q   <= ovf_d;
        end
    end

    // Entry storage needs no reset: it is only visible through the gated
    // outputs below, and the tail slot written here is never the head being
    // read while the FIFO is non-full.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            data_mem_q[wr_q] <= evict_data_i;
            tag_mem_q[wr_q]  <= evict_tag_i;
            stat_mem_q[wr_q] <= evict_stat_i;
        end
    end

    assign head_data = data_mem_q[rd_q];

    // Data-path outputs are forced to 0 outside SEND so every output is 0
    // during and right after reset.
    always_comb begin
        wb_v_o    = (state_q == SEND);
        wb_tag_o  = '0;
        wb_stat_o = '0;
        wb_beat_o = '0;
        wb_last_o = 1'b0;
        wb_data_o = '0;
        if (state_q == SEND) begin
            wb_tag_o  = tag_mem_q[rd_q];
            wb_stat_o = stat_mem_q[rd_q];
            wb_beat_o = beat_q;
            wb_last_o = (beat_q == last_beat_lp);
            wb_data_o = head_data[beat_q * beat_width +: beat_width];
        end
    end

    assign full_o     = full;
    assign overflow_o = ovf_q;
    assign busy_o     = (cnt_q != '0) | (state_q == SEND);

endmodule

// File: tb/tb_bp_vc_wb_drain.sv
// Testbench for bp_vc_wb_drain: directed phases followed by a random phase,
// checked every cycle against a queue-based model of the drain buffer and a
// beat scoreboard fed from accepted evictions.
module tb_bp_vc_wb_drain;

    localparam int BW = 512;
    localparam int TW = 28;
    localparam int SW = 2;
    localparam int DW = 64;
    localparam int FE = 2;
    localparam int NB = BW / DW;
    localparam int IW = $clog2(NB);

    // clock / reset
    logic clk_i = 1'b0;
    logic reset = 1'b0;
    always #5 clk_i = ~clk_i;

    logic          evict_i = 1'b0;
    logic [BW-1:0] evict_data_i = '0;
    logic [TW-1:0] evict_tag_i = '0;
    logic [SW-1:0] evict_stat_i = '0;
    logic          wb_ready_i = 1'b0;
    logic          full_o, overflow_o, wb_v_o, wb_last_o, busy_o;
    logic [TW-1:0] wb_tag_o;
    logic [SW-1:0] wb_stat_o;
    logic [IW-1:0] wb_beat_o;
    logic [DW-1:0] wb_data_o;

    bp_vc_wb_drain #(
        .block_width(BW), .tag_width(TW), .stat_width(SW),
        .beat_width(DW), .fifo_els(FE)
    ) dut (
        .clk_i(clk_i), .reset(reset),
        .evict_i(evict_i), .evict_data_i(evict_data_i),
        .evict_tag_i(evict_tag_i), .evict_stat_i(evict_stat_i),
        .full_o(full_o), .overflow_o(overflow_o),
        .wb_v_o(wb_v_o), .wb_ready_i(wb_ready_i),
        .wb_tag_o(wb_tag_o), .wb_stat_o(wb_stat_o),
        .wb_beat_o(wb_beat_o), .wb_last_o(wb_last_o),
        .wb_data_o(wb_data_o), .busy_o(busy_o)
    );

    // reference model: queue of buffered blocks plus drain progress
    typedef struct {
        logic [TW-1:0] tag;
        logic [SW-1:0] stat;
        logic [BW-1:0] data;
    } blk_t;

    blk_t          mq[$];
    bit            m_send = 1'b0;
    int            m_beat = 0;
    bit            m_ovf  = 1'b0;
    logic [DW-1:0] exp_q[$];
    int            n_assert = 0;
    int            n_fail   = 0;
    int            v_cnt    = 0;

    task automatic chk(input string name, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] rnd_blk();
        logic [BW-1:0] r;
        for (int i = 0; i < BW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [BW-1:0] idx_blk();
        logic [BW-1:0] r;
        for (int i = 0; i < NB; i++) r[i*DW +: DW] = DW'(i);
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_send = 1'b0;
        m_beat = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic check_outputs();
        blk_t          h;
        logic [DW-1:0] slice;
        chk("wb_v", wb_v_o, m_send);
        chk("full", full_o, mq.size() == FE);
        chk("overflow", overflow_o, m_ovf);
        chk("busy", busy_o, (mq.size() != 0) || m_send);
        if (wb_v_o) v_cnt++;
        if (m_send && mq.size() > 0) begin
            h     = mq[0];
            slice = h.data[m_beat*DW +: DW];
            chk("wb_tag", wb_tag_o, h.tag);
            chk("wb_stat", wb_stat_o, h.stat);
            chk("wb_beat", wb_beat_o, m_beat);
            chk("wb_last", wb_last_o, m_beat == NB - 1);
            chk("wb_data", wb_data_o, slice);
        end
    endtask

    // driver: check the current cycle, apply inputs, advance the model, clock
    task automatic step(input bit ev, input logic [TW-1:0] tg, input logic [SW-1:0] st,
                        input logic [BW-1:0] dt, input bit rdy);
        bit   full_pre, fire, last, push;
        blk_t b;
        check_outputs();
        evict_i      = ev;
        evict_tag_i  = tg;
        evict_stat_i = st;
        evict_data_i = dt;
        wb_ready_i   = rdy;
        if (wb_v_o && rdy) begin
            if (exp_q.size() == 0) chk("sb_unexpected_beat", 1'b1, 1'b0);
            else chk("sb_beat", wb_data_o, exp_q.pop_front());
        end
        full_pre = (mq.size() == FE);
        fire     = m_send && rdy;
        last     = fire && (m_beat == NB - 1);
        push     = ev && !full_pre && (st != '0);
        if (ev && full_pre) m_ovf = 1'b1;
        if (!m_send) begin
            if (mq.size() > 0) begin
                m_send = 1'b1;
                m_beat = 0;
            end
        end else if (fire) begin
            if (last) begin
                b = mq.pop_front();
                m_beat = 0;
            end else begin
                m_beat++;
            end
        end
        if (push) begin
            b.tag = tg; b.stat = st; b.data = dt;
            mq.push_back(b);
            for (int i = 0; i < NB; i++) exp_q.push_back(dt[i*DW +: DW]);
        end
        if (last) m_send = (mq.size() > 0);
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, rdy);
    endtask

    // evict tg on the cycle the current block's last beat is accepted
    task automatic inject_at_last(input logic [TW-1:0] tg, input string name);
        bit done = 1'b0;
        for (int i = 0; i < 3 * NB; i++) begin
            if (!done && m_send && m_beat == NB - 1) begin
                step(1'b1, tg, 2'b10, rnd_blk(), 1'b1);
                done = 1'b1;
            end else begin
                step(1'b0, '0, '0, '0, 1'b1);
            end
        end
        chk(name, done, 1'b1);
    endtask

    initial begin
        bit reached;

        // reset held: every output low
        @(negedge clk_i);
        chk("rst_wb_v", wb_v_o, 1'b0);
        chk("rst_full", full_o, 1'b0);
        chk("rst_overflow", overflow_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_data", wb_data_o, '0);
        chk("rst_tag", wb_tag_o, '0);
        #2 reset = 1'b1;
        @(negedge clk_i);

        // single block, ready held high: 8 beats of data i
        v_cnt = 0;
        step(1'b1, TW'('h1234), 2'b11, idx_blk(), 1'b1);
        idle(12, 1'b1);
        chk("single_valid_cycles", v_cnt, 8);
        chk("single_sb_empty", exp_q.size(), 0);

        // back-pressure: ready 1,0,0 repeating
        step(1'b1, TW'('h2222), 2'b01, rnd_blk(), 1'b0);
        for (int i = 0; i < 30; i++) step(1'b0, '0, '0, '0, (i % 3) == 0);
        chk("bp_sb_empty", exp_q.size(), 0);

        // clean eviction is dropped
        step(1'b1, TW'('h55), 2'b00, rnd_blk(), 1'b1);
        idle(3, 1'b1);

        // enqueue during last-beat pop with one block in flight
        step(1'b1, TW'('hA), 2'b11, rnd_blk(), 1'b1);
        inject_at_last(TW'('hD), "inject_simul");
        idle(12, 1'b1);
        chk("simul_sb_empty", exp_q.size(), 0);

        // full and overflow: A, B fill the FIFO, C overflows
        step(1'b1, TW'('hA), 2'b11, rnd_blk(), 1'b0);
        step(1'b1, TW'('hB), 2'b10, rnd_blk(), 1'b0);
        step(1'b1, TW'('hC), 2'b01, rnd_blk(), 1'b0);
        idle(3, 1'b0);
        // while full, a pop does not free space for the same-cycle eviction
        inject_at_last(TW'('hE), "inject_full");
        idle(12, 1'b1);
        chk("full_sb_empty", exp_q.size(), 0);

        // reset in the middle of a drain at beat 3
        step(1'b1, TW'('h77), 2'b11, rnd_blk(), 1'b1);
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            if (m_send && m_beat == 3) reached = 1'b1;
            else step(1'b0, '0, '0, '0, 1'b1);
        end
        chk("reach_beat3", reached, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_wb_v", wb_v_o, 1'b0);
        chk("mid_rst_busy", busy_o, 1'b0);
        chk("mid_rst_overflow", overflow_o, 1'b0);
        chk("mid_rst_full", full_o, 1'b0);
        chk("mid_rst_data", wb_data_o, '0);
        model_reset();
        evict_i = 1'b0;
        @(negedge clk_i);
        reset = 1'b1;
        step(1'b1, TW'('h88), 2'b10, rnd_blk(), 1'b1);
        idle(12, 1'b1);

        // random phase
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 4) == 0, TW'($urandom), SW'($urandom_range(0, 3)),
                 rnd_blk(), $urandom_range(0, 3) != 0);
        end
        idle(40, 1'b1);
        chk("final_sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
